// File: rtl/zxuno_bridge_pkg.sv
// Shared constants and FIFO entry layout for the ZX-Uno core bridge.
package zxuno_bridge_pkg;

  // Default ZX-Uno register numbers and the core-side control address
  localparam logic [7:0] DATA_REG_DEF  = 8'hFA;
  localparam logic [7:0] PTR_REG_DEF   = 8'hFB;
  localparam logic [7:0] SEL_REG_DEF   = 8'hFC;
  localparam logic [7:0] CTRL_ADDR_DEF = 8'hCA;

  // One posted write. The address field is always 8 bits; narrower cores
  // use the low AW bits. ctrl marks a write to the control address.
  typedef struct packed {
    logic       ctrl;
    logic [2:0] chan;
    logic [7:0] addr;
    logic [7:0] data;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

  // One-hot decode of a 3-bit channel number
  function automatic logic [7:0] chan_onehot(input logic [2:0] c);
    return 8'b1 << c;
  endfunction

endpackage

// File: rtl/bridge_fifo.sv
// Synchronous FIFO with full/empty flags. A push while full is accepted
// only when a pop happens in the same cycle; a pop while empty is ignored.
module bridge_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wp;
  logic [PW:0]  rp;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rp[PW-1:0]];

  // Pointer update; reset discards all queued entries
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  // Storage write, no reset needed since the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/zxuno_core_bridge.sv
// Bridge from the ZX-Uno register port to up to eight attached cores.
// Host writes to DATA_REG are posted through a FIFO and drained to the
// selected core; host reads of DATA_REG go straight to the core.
//
// Core write handshake: core_ready[c] is the core's ready; the bridge's
// valid is core_wr with core_sel[c] set. A write transfers in exactly the
// cycle where both are high, and the entry is popped in that same cycle.
module zxuno_core_bridge
  import zxuno_bridge_pkg::*;
#(
  parameter int         NCH        = 2,
  parameter int         AW         = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] DATA_REG   = DATA_REG_DEF,
  parameter logic [7:0] PTR_REG    = PTR_REG_DEF,
  parameter logic [7:0] SEL_REG    = SEL_REG_DEF,
  parameter logic [7:0] CTRL_ADDR  = CTRL_ADDR_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       zxuno_addr,
  input  logic             zxuno_regrd,
  input  logic             zxuno_regwr,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             oe_n,
  output logic [AW-1:0]    core_addr,
  output logic [7:0]       core_dout,
  output logic             core_wr,
  output logic             core_rd,
  output logic [NCH-1:0]   core_sel,
  input  logic [NCH*8-1:0] core_din,
  input  logic [NCH-1:0]   core_ready,
  output logic [NCH-1:0]   core_step,
  output logic [NCH-1:0]   core_reset
);

  logic [AW-1:0] ptr;
  logic [2:0]    chan;
  logic          autoinc;
  logic          ovf;

  // Edge detection state; armed stays low for the first cycle after reset
  // so a strobe already high at release is not taken as an edge.
  logic armed, rd_q, wr_q, data_rd_q;

  logic        is_data, is_ptr, is_sel;
  logic        rd_edge, wr_edge, data_wr;
  logic        data_rd_level, data_rd_fall;
  logic [7:0]  ptr_ext;
  logic        is_ctrl;
  logic [2:0]  chan_wr;
  logic        stall;
  logic [7:0]  ready_ext;
  logic [63:0] din_ext;
  logic [7:0]  sel_status;

  fifo_entry_t push_entry;
  fifo_entry_t head;
  logic [ENTRY_W-1:0] head_bits;
  logic fifo_full, fifo_empty, push, pop;
  logic drain_wr, drain_ctrl;

  assign is_data = (zxuno_addr == DATA_REG);
  assign is_ptr  = (zxuno_addr == PTR_REG);
  assign is_sel  = (zxuno_addr == SEL_REG);

  assign rd_edge = armed & zxuno_regrd & ~rd_q;
  assign wr_edge = armed & zxuno_regwr & ~wr_q;
  assign data_wr = wr_edge & is_data;

  // A DATA_REG read holds the core bus at ptr for the whole strobe
  assign data_rd_level = zxuno_regrd & is_data;
  assign data_rd_fall  = data_rd_q & ~data_rd_level;

  assign ptr_ext   = 8'(ptr);
  assign is_ctrl   = (ptr_ext == CTRL_ADDR);
  assign chan_wr   = (int'(din[2:0]) >= NCH) ? 3'(NCH - 1) : din[2:0];
  assign ready_ext = 8'(core_ready);
  assign din_ext   = 64'(core_din);

  assign push_entry = '{ctrl: is_ctrl, chan: chan, addr: ptr_ext, data: din};
  assign head       = fifo_entry_t'(head_bits);

  // core_rd covers a one-cycle strobe that already dropped, keeping
  // core_wr and core_rd mutually exclusive
  assign stall      = data_rd_level | core_rd;
  assign drain_wr   = ~fifo_empty & ~head.ctrl & ready_ext[head.chan] & ~stall;
  assign drain_ctrl = ~fifo_empty & head.ctrl & ~stall;
  assign pop        = drain_wr | drain_ctrl;
  assign push       = data_wr & (~fifo_full | pop);

  assign sel_status = {autoinc, ovf, fifo_full, fifo_empty, 1'b0, chan};

  bridge_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Core bus: drained entry when writing, otherwise the host pointer/channel
  always_comb begin
    core_wr   = drain_wr;
    core_addr = ptr;
    core_dout = 8'h00;
    core_sel  = NCH'(chan_onehot(chan));
    if (drain_wr) begin
      core_addr = AW'(head.addr);
      core_dout = head.data;
      core_sel  = NCH'(chan_onehot(head.chan));
    end
  end

  // Host read mux; bus released unless a bridge register is being read
  always_comb begin
    dout = 8'h00;
    oe_n = 1'b1;
    if (zxuno_regrd) begin
      if (is_data) begin
        dout = din_ext[{chan, 3'b000} +: 8];
        oe_n = 1'b0;
      end else if (is_ptr) begin
        dout = ptr_ext;
        oe_n = 1'b0;
      end else if (is_sel) begin
        dout = sel_status;
        oe_n = 1'b0;
      end
    end
  end

  // Host register state, edge detectors and the core read pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed     <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      data_rd_q <= 1'b0;
      core_rd   <= 1'b0;
      ptr       <= '0;
      chan      <= '0;
      autoinc   <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      armed     <= 1'b1;
      rd_q      <= zxuno_regrd;
      wr_q      <= zxuno_regwr;
      data_rd_q <= data_rd_level & (rd_edge | data_rd_q);
      core_rd   <= rd_edge & is_data;

      if (wr_edge & is_ptr) begin
        ptr <= din[AW-1:0];
      end else if (autoinc & ((push & ~is_ctrl) | data_rd_fall)) begin
        ptr <= ptr + 1'b1;
      end

      if (wr_edge & is_sel) begin
        chan    <= chan_wr;
        autoinc <= din[7];
        ovf     <= 1'b0;
      end else if (data_wr & ~push) begin
        ovf <= 1'b1;
      end
    end
  end

  // Control entries load the per-core reset/step bits as they pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_step  <= '0;
      core_reset <= '0;
    end else if (drain_ctrl) begin
      for (int i = 0; i < NCH; i++) begin
        if (head.chan == 3'(i)) begin
          core_reset[i] <= head.data[1];
          core_step[i]  <= head.data[0];
        end
      end
    end
  end

endmodule

// File: tb/tb_zxuno_core_bridge.sv
// Directed bench for zxuno_core_bridge with default parameters.
module tb_zxuno_core_bridge;

  localparam int NCH = 2;
  localparam int AW  = 8;
  localparam logic [7:0] DATA_REG  = 8'hFA;
  localparam logic [7:0] PTR_REG   = 8'hFB;
  localparam logic [7:0] SEL_REG   = 8'hFC;
  localparam logic [7:0] CTRL_ADDR = 8'hCA;
  localparam int EW = NCH + AW + 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       zxuno_addr;
  logic             zxuno_regrd;
  logic             zxuno_regwr;
  logic [7:0]       din;
  logic [7:0]       dout;
  logic             oe_n;
  logic [AW-1:0]    core_addr;
  logic [7:0]       core_dout;
  logic             core_wr;
  logic             core_rd;
  logic [NCH-1:0]   core_sel;
  logic [NCH*8-1:0] core_din;
  logic [NCH-1:0]   core_ready;
  logic [NCH-1:0]   core_step;
  logic [NCH-1:0]   core_reset;

  int checks = 0;
  int errors = 0;

  // Write monitor state
  logic [EW-1:0] got_q[$];
  logic [EW-1:0] exp_q[$];
  int  wr_count   = 0;
  bit  both_seen  = 0;
  bit  step_seen  = 0;
  int  wr_at_step = -1;

  // Results of host_read
  logic [7:0]     r_d;
  logic           r_oe;
  logic [AW-1:0]  r_ca;
  logic [NCH-1:0] r_sel;
  bit             r_st;
  int             r_pl;

  zxuno_core_bridge dut (
    .clk         (clk),
    .reset       (reset),
    .zxuno_addr  (zxuno_addr),
    .zxuno_regrd (zxuno_regrd),
    .zxuno_regwr (zxuno_regwr),
    .din         (din),
    .dout        (dout),
    .oe_n        (oe_n),
    .core_addr   (core_addr),
    .core_dout   (core_dout),
    .core_wr     (core_wr),
    .core_rd     (core_rd),
    .core_sel    (core_sel),
    .core_din    (core_din),
    .core_ready  (core_ready),
    .core_step   (core_step),
    .core_reset  (core_reset)
  );

  // Clock
  always #5 clk = ~clk;

  // Capture every core write and ordering information on the falling edge
  always @(negedge clk) begin
    if (core_wr) begin
      got_q.push_back({core_sel, core_addr, core_dout});
      wr_count++;
    end
    if (core_wr && core_rd) both_seen = 1;
    if (core_step[1] && !step_seen) begin
      step_seen  = 1;
      wr_at_step = wr_count;
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    zxuno_addr  = a;
    din         = d;
    zxuno_regwr = 1'b1;
    @(posedge clk); #1;
    zxuno_regwr = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a, input int n,
                           output logic [7:0] d, output logic oe,
                           output logic [AW-1:0] ca, output logic [NCH-1:0] sl,
                           output bit stable, output int pulses);
    @(posedge clk); #1;
    zxuno_addr  = a;
    zxuno_regrd = 1'b1;
    @(negedge clk);
    d = dout; oe = oe_n; ca = core_addr; sl = core_sel;
    stable = 1; pulses = 0;
    if (core_rd) pulses++;
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      if (dout !== d) stable = 0;
      if (core_rd) pulses++;
    end
    @(posedge clk); #1;
    zxuno_regrd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (core_rd) pulses++;
    end
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    zxuno_addr  = PTR_REG;
    din         = 8'h55;
    zxuno_regwr = 1'b1;
    zxuno_regrd = 1'b0;
    core_ready  = '0;
    core_din    = '0;
    repeat (2) @(negedge clk);
    checks++; if ({core_wr, core_rd} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {core_wr, core_rd}); end
    checks++; if ({core_step, core_reset} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl_bits: got %b expected 0000", {core_step, core_reset}); end
    checks++; if ({oe_n, dout} !== 9'h100) begin errors++; $display("FAIL reset_idle_bus: got oe_n=%b dout=%h expected 1/00", oe_n, dout); end
    // Release with regwr already high at PTR_REG: must not load ptr
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 zxuno_regwr = 1'b0;
    host_read(PTR_REG, 1, r_d, r_oe, r_ca, r_sel, r_st, r_pl);
    checks++; if (r_d !== 8'h00) begin errors++; $display("FAIL reset_no_first_edge_ptr: got %h expected 00", r_d); end
    checks++; if (r_oe !== 1'b0) begin errors++; $display("FAIL reg_read_oe: got %b expected 0", r_oe); end
    host_read(SEL_REG, 1, r_d, r_oe, r_ca, r_sel, r_st, r_pl);
    checks++; if (r_d !== 8'h10) begin errors++; $display("FAIL reset_sel_status: got %h expected 10", r_d); end
  endtask

  task automatic test_autoinc_write();
    core_ready = 2'b11;
    got_q.delete();
    host_write(PTR_REG, 8'h10);
    host_write(SEL_REG, 8'h80);
    host_write(DATA_REG, 8'hAA);
    host_write(DATA_REG, 8'hBB);
    repeat (4) @(negedge clk);
    exp_q = '{{2'b01, 8'h10, 8'hAA}, {2'b01, 8'h11, 8'hBB}};
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL autoinc_wr_count: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL autoinc_wr_%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    host_read(PTR_REG, 1, r_d, r_oe, r_ca, r_sel, r_st, r_pl);
    checks++; if (r_d !== 8'h12) begin errors++; $display("FAIL autoinc_ptr: got %h expected 12", r_d); end
  endtask

  task automatic test_overflow();
    apply_reset();
    core_ready = 2'b00;
    host_write(SEL_REG, 8'h00);
    host_write(PTR_REG, 8'h20);
    for (int i = 1; i <= 3; i++) host_write(DATA_REG, 8'(i));
    host_read(SEL_REG, 1, r_d, r_oe, r_ca, r_sel, r_st, r_pl);
    checks++; if (r_d !== 8'h00) begin errors++; $display("FAIL ovf_three_queued: got %h expected 00", r_d); end
    host_write(DATA_REG, 8'h04);
    host_read(SEL_REG, 1, r_d, r_oe, r_ca, r_sel, r_st, r_pl);
    checks++; if (r_d !== 8'h20) begin errors++; $display("FAIL ovf_fourth_full: got %h expected 20", r_d); end
    host_write(DATA_REG, 8'h05);
    host_read(SEL_REG, 1, r_d, r_oe, r_ca, r_sel, r_st, r_pl);
    checks++; if (r_d !== 8'h60) begin errors++; $display("FAIL ovf_fifth_dropped: got %h expected 60", r_d); end
    got_q.delete();
    @(posedge clk); #1 core_ready = 2'b11;
    repeat (8) @(negedge clk);
    exp_q = '{{2'b01, 8'h20, 8'h01}, {2'b01, 8'h20, 8'h02}, {2'b01, 8'h20, 8'h03}, {2'b01, 8'h20, 8'h04}};
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL ovf_drain_count: got %0d expected 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_drain_%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    host_read(SEL_REG, 1, r_d, r_oe, r_ca, r_sel, r_st, r_pl);
    checks++; if (r_d !== 8'h50) begin errors++; $display("FAIL ovf_sticky: got %h expected 50", r_d); end
    host_write(SEL_REG, 8'h00);
    host_read(SEL_REG, 1, r_d, r_oe, r_ca, r_sel, r_st, r_pl);
    checks++; if (r_d !== 8'h10) begin errors++; $display("FAIL ovf_cleared: got %h expected 10", r_d); end
    // Out-of-range channel clamps to NCH-1
    host_write(SEL_REG, 8'h07);
    host_read(SEL_REG, 1, r_d, r_oe, r_ca, r_sel, r_st, r_pl);
    checks++; if (r_d !== 8'h11) begin errors++; $display("FAIL sel_clamp: got %h expected 11", r_d); end
  endtask

  task automatic test_ctrl_order();
    core_ready = 2'b00;
    host_write(SEL_REG, 8'h81);
    host_write(PTR_REG, 8'h30);
    host_write(DATA_REG, 8'h11);
    host_write(DATA_REG, 8'h22);
    host_write(PTR_REG, CTRL_ADDR);
    host_write(DATA_REG, 8'h03);
    repeat (3) @(negedge clk);
    checks++; if ({core_reset, core_step} !== 4'b0000) begin errors++; $display("FAIL ctrl_blocked: got %b expected 0000", {core_reset, core_step}); end
    host_read(PTR_REG, 1, r_d, r_oe, r_ca, r_sel, r_st, r_pl);
    checks++; if (r_d !== CTRL_ADDR) begin errors++; $display("FAIL ctrl_ptr_no_inc: got %h expected %h", r_d, CTRL_ADDR); end
    got_q.delete();
    wr_count  = 0;
    step_seen = 0;
    @(posedge clk); #1 core_ready = 2'b10;
    repeat (6) @(negedge clk);
    exp_q = '{{2'b10, 8'h30, 8'h11}, {2'b10, 8'h31, 8'h22}};
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL ctrl_data_count: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ctrl_data_%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if ({core_reset, core_step} !== 4'b1010) begin errors++; $display("FAIL ctrl_bits: got %b expected 1010", {core_reset, core_step}); end
    checks++; if (wr_at_step !== 2) begin errors++; $display("FAIL ctrl_after_data: got %0d writes before step, expected 2", wr_at_step); end
    host_read(PTR_REG, 1, r_d, r_oe, r_ca, r_sel, r_st, r_pl);
    checks++; if (r_d !== CTRL_ADDR) begin errors++; $display("FAIL ctrl_ptr_final: got %h expected %h", r_d, CTRL_ADDR); end
  endtask

  task automatic test_data_read();
    core_din = {8'h5A, 8'hC3};
    host_write(SEL_REG, 8'h80);
    host_write(PTR_REG, 8'hFF);
    host_read(DATA_REG, 6, r_d, r_oe, r_ca, r_sel, r_st, r_pl);
    checks++; if (r_d !== 8'hC3) begin errors++; $display("FAIL rd_data: got %h expected C3", r_d); end
    checks++; if ({r_oe, r_ca, r_sel} !== {1'b0, 8'hFF, 2'b01}) begin errors++; $display("FAIL rd_bus: got oe=%b addr=%h sel=%b expected 0/FF/01", r_oe, r_ca, r_sel); end
    checks++; if (r_st !== 1'b1) begin errors++; $display("FAIL rd_stable: got %b expected 1", r_st); end
    checks++; if (r_pl !== 1) begin errors++; $display("FAIL rd_pulse_count: got %0d expected 1", r_pl); end
    host_read(PTR_REG, 1, r_d, r_oe, r_ca, r_sel, r_st, r_pl);
    checks++; if (r_d !== 8'h00) begin errors++; $display("FAIL rd_ptr_wrap: got %h expected 00", r_d); end
    host_write(SEL_REG, 8'h01);
    host_read(DATA_REG, 1, r_d, r_oe, r_ca, r_sel, r_st, r_pl);
    checks++; if ({r_d, r_sel} !== {8'h5A, 2'b10}) begin errors++; $display("FAIL rd_chan1: got %h/%b expected 5A/10", r_d, r_sel); end
    checks++; if (r_pl !== 1) begin errors++; $display("FAIL rd_short_pulse: got %0d expected 1", r_pl); end
    host_read(PTR_REG, 1, r_d, r_oe, r_ca, r_sel, r_st, r_pl);
    checks++; if (r_d !== 8'h00) begin errors++; $display("FAIL rd_ptr_hold: got %h expected 00", r_d); end
    @(negedge clk);
    checks++; if ({oe_n, dout} !== 9'h100) begin errors++; $display("FAIL idle_bus: got oe_n=%b dout=%h expected 1/00", oe_n, dout); end
  endtask

  task automatic test_reset_mid_drain();
    core_ready = 2'b00;
    host_write(SEL_REG, 8'h00);
    host_write(PTR_REG, 8'h40);
    for (int i = 1; i <= 3; i++) host_write(DATA_REG, 8'(8'h40 + i));
    @(posedge clk); #1 core_ready = 2'b11;
    @(negedge clk);
    checks++; if (core_wr !== 1'b1) begin errors++; $display("FAIL mid_drain_started: got %b expected 1", core_wr); end
    @(posedge clk); #3 reset = 1'b1;
    #1;
    wr_count = 0;
    checks++; if ({core_wr, core_rd, core_step, core_reset} !== 6'b0) begin errors++; $display("FAIL mid_reset_clear: got %b expected 000000", {core_wr, core_rd, core_step, core_reset}); end
    @(negedge clk) reset = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (wr_count !== 0) begin errors++; $display("FAIL mid_reset_no_wr: got %0d writes expected 0", wr_count); end
    host_read(SEL_REG, 1, r_d, r_oe, r_ca, r_sel, r_st, r_pl);
    checks++; if (r_d !== 8'h10) begin errors++; $display("FAIL mid_reset_empty: got %h expected 10", r_d); end
  endtask

  initial begin
    test_reset();
    test_autoinc_write();
    test_overflow();
    test_ctrl_order();
    test_data_read();
    test_reset_mid_drain();
    checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL wr_rd_exclusive: got overlap=%b expected 0", both_seen); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zxuno_core_bridge.md
ZXUNO_CORE_BRIDGE -- requirements
Module: zxuno_core_bridge

Interface
REQ-001 Parameter NCH, default 2: number of attached cores, 1..8.
REQ-002 Parameter AW, default 8: core address width, 1..8.
REQ-003 Parameter FIFO_DEPTH, default 4: write-post FIFO entries, power of two, 2..16.
REQ-004 Parameters DATA_REG 8'hFA, PTR_REG 8'hFB, SEL_REG 8'hFC: ZX-Uno register numbers.
REQ-005 Parameter CTRL_ADDR, default 8'hCA: core address decoded as the control register.
REQ-006 clk  in  1  single clock; all logic is rising-edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 zxuno_addr  in  8  ZX-Uno register number; zxuno_regrd/zxuno_regwr  in  1 each  level strobes.
REQ-009 din  in  8  host write data; dout  out  8  host read data; oe_n  out  1  read-drive enable, low while driving.
REQ-010 core_addr  out  AW; core_dout  out  8; core_wr  out  1; core_rd  out  1; core_sel  out  NCH  one-hot target core.
REQ-011 core_din  in  NCH*8  per-core read data; core_ready  in  NCH  core accepts a write this cycle.
REQ-012 core_step, core_reset  out  NCH each  registered per-core control bits.

Function
REQ-013 Host access detection SHALL be edge-based: one action per rising edge of regrd or regwr at a given register, independent of strobe length.
REQ-014 PTR_REG write SHALL load ptr <= din[AW-1:0]; PTR_REG read SHALL return ptr, zero-extended.
REQ-015 SEL_REG write SHALL set chan <= din[2:0] (values >= NCH clamp to NCH-1), autoinc <= din[7], and clear ovf.
REQ-016 SEL_REG read SHALL return {autoinc, ovf, fifo_full, fifo_empty, 1'b0, chan}.
REQ-017 DATA_REG write SHALL enqueue {ctrl = (ptr==CTRL_ADDR), chan, ptr, din}; if FIFO full, the write is dropped and ovf is set (sticky).
REQ-018 DATA_REG read SHALL return core_din byte [chan] combinationally, with core_addr=ptr and core_sel=chan, and SHALL pulse core_rd for exactly one cycle at the regrd rising edge.
REQ-019 While zxuno_regrd is high at DATA_REG, FIFO drain SHALL stall so core_addr stays at ptr.
REQ-020 Drain: when the head entry is non-ctrl and core_ready[entry chan] is high, the block SHALL drive core_addr/core_dout/core_sel from the entry, pulse core_wr for one cycle, and pop it; one pop per cycle maximum.
REQ-021 A ctrl head entry SHALL pop without waiting for core_ready and SHALL load {core_reset, core_step}[chan] <= data[1:0] on the pop cycle; FIFO order is therefore preserved between data and control writes.
REQ-022 With autoinc=1, ptr SHALL increment by 1 mod 2^AW on the cycle after a non-ctrl DATA_REG write is accepted, and on the regrd falling edge of a DATA_REG read; control writes and dropped writes never increment.
REQ-023 A simultaneous enqueue and pop at full SHALL be accepted; pop at empty SHALL not occur.
REQ-024 When no register read is decoded, oe_n=1 and dout=8'h00.
REQ-025 core_wr and core_rd SHALL never be high in the same cycle.

Reset
REQ-026 Asserting reset SHALL asynchronously clear ptr, chan, autoinc, ovf, FIFO pointers, core_step, core_reset, core_wr, core_rd, and the edge detectors; queued entries are discarded.
REQ-027 After reset release, the first regrd/regwr that is already high SHALL NOT count as an edge.

Structure
REQ-028 Package zxuno_bridge_pkg SHALL hold the register-number defaults, CTRL_ADDR, and the FIFO entry typedef.
REQ-029 Sub-module bridge_fifo (synchronous FIFO, parametrised width/depth, full/empty flags) SHALL be instantiated once.

Verification
REQ-030 PTR=8'h10, SEL=8'h80, write 8'hAA and 8'hBB with core_ready=1 -> core_wr pulses at addr 10 then 11 with data AA, BB; PTR reads 8'h12.
REQ-031 core_ready=0, five writes, FIFO_DEPTH=4 -> fourth sets fifo_full, fifth dropped, SEL read bit6=1; then ready=1 drains exactly 4 in order.
REQ-032 PTR=CTRL_ADDR, chan=1, write 8'h03 after two queued data writes -> core_reset[1]=core_step[1]=1 only after both data pops; ptr unchanged.
REQ-033 autoinc=1, ptr=8'hFF, 6-cycle DATA_REG read -> single core_rd pulse, dout stable for the full strobe, ptr=8'h00 afterwards.
REQ-034 Reset asserted mid-drain with 3 entries queued -> outputs clear immediately, fifo_empty=1, no further core_wr after release.
